// File: rtl/mod_setting_loader_if.sv
// Bundle between the setting loader, its controller BRAM read port and the
// settings consumer.
//   CTL_ADDR / CTL_DOUT : BRAM read address out, read data back
//   MEM_WR_SEGMENT .. TRANSITION_VALUE : committed setting outputs
//   UPDATE : one-cycle pulse in the cycle the outputs take new values
// master = loader side, slave = BRAM/consumer side.
interface mod_setting_loader_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic [ADDR_W-1:0] CTL_ADDR;
  logic [DATA_W-1:0] CTL_DOUT;
  logic              MEM_WR_SEGMENT;
  logic              REQ_RD_SEGMENT;
  logic [15:0]       CYCLE0;
  logic [15:0]       CYCLE1;
  logic [31:0]       FREQ_DIV0;
  logic [31:0]       FREQ_DIV1;
  logic [31:0]       REP0;
  logic [31:0]       REP1;
  logic [7:0]        TRANSITION_MODE;
  logic [63:0]       TRANSITION_VALUE;
  logic              UPDATE;

  modport master (
    output CTL_ADDR,
    input  CTL_DOUT,
    output MEM_WR_SEGMENT, REQ_RD_SEGMENT, CYCLE0, CYCLE1, FREQ_DIV0,
           FREQ_DIV1, REP0, REP1, TRANSITION_MODE, TRANSITION_VALUE, UPDATE
  );

  modport slave (
    input  CTL_ADDR,
    output CTL_DOUT,
    input  MEM_WR_SEGMENT, REQ_RD_SEGMENT, CYCLE0, CYCLE1, FREQ_DIV0,
           FREQ_DIV1, REP0, REP1, TRANSITION_MODE, TRANSITION_VALUE, UPDATE
  );
endinterface

// File: rtl/mod_setting_loader.sv
// Watches the mod-set flag (bit 0 of controller word 0x00). On a rising edge
// it reads words 0x20..0x30 into shadow registers, then commits them to the
// setting outputs all at once with a one-cycle UPDATE pulse.
// Ports:
//   CLK : system clock, rising edge
//   RST : synchronous active-high reset
//   bus : mod_setting_loader_if.master (BRAM read port + setting outputs)
// Parameter ReadLatency (1..4): BRAM cycles from address to data.
module mod_setting_loader #(
  parameter int unsigned ReadLatency = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  mod_setting_loader_if.master        bus
);
  localparam int unsigned ADDR_W           = 8;
  localparam int unsigned DATA_W           = 16;
  localparam int unsigned NUM_WORDS        = 17;
  localparam int unsigned IDX_W            = 5;
  localparam int unsigned CTL_FLAG_MOD_SET = 0;
  localparam logic [ADDR_W-1:0] ADDR_CTL_FLAG = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_FIRST    = 8'h20;
  localparam logic [ADDR_W-1:0] ADDR_LAST     = 8'h30;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issue_q, issue_d;
  logic              start_load;
  logic              commit;

  logic [ReadLatency-1:0] tag_vld_q;
  logic [ADDR_W-1:0]      tag_addr_q [ReadLatency];
  logic [DATA_W-1:0]      shadow_q   [NUM_WORDS];
  logic                   flag_prev_q;

  logic              ret_vld;
  logic [ADDR_W-1:0] ret_addr;
  logic [IDX_W-1:0]  ret_idx;
  logic              flag_sample;
  logic              flag_rise;
  logic              data_hit;
  logic              last_hit;

  logic              mem_wr_q, req_rd_q, update_q;
  logic [15:0]       cycle0_q, cycle1_q;
  logic [31:0]       freq_div0_q, freq_div1_q, rep0_q, rep1_q;
  logic [7:0]        trans_mode_q;
  logic [63:0]       trans_value_q;

  // Returning read is identified purely by the tag that left with its address.
  assign ret_vld     = tag_vld_q[ReadLatency-1];
  assign ret_addr    = tag_addr_q[ReadLatency-1];
  assign ret_idx     = IDX_W'(ret_addr - ADDR_FIRST);
  assign flag_sample = ret_vld && (ret_addr == ADDR_CTL_FLAG);
  assign flag_rise   = flag_sample && !flag_prev_q && bus.CTL_DOUT[CTL_FLAG_MOD_SET];
  assign data_hit    = ret_vld && (ret_addr >= ADDR_FIRST) && (ret_addr <= ADDR_LAST);
  assign last_hit    = ret_vld && (ret_addr == ADDR_LAST);

  // Next state and next issued address.
  always_comb begin
    state_d    = state_q;
    addr_d     = ADDR_CTL_FLAG;
    issue_d    = 1'b1;
    start_load = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flag_rise) begin
          state_d    = LOAD;
          addr_d     = ADDR_FIRST;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        // Issue 0x20..0x30 back to back, then idle the port until 0x30 returns.
        issue_d = 1'b0;
        if (issue_q && (addr_q != ADDR_LAST)) begin
          addr_d  = addr_q + 8'd1;
          issue_d = 1'b1;
        end
        if (last_hit) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        commit  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and address register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= ADDR_CTL_FLAG;
      issue_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
    end
  end

  // Tag valids; flushed when a load starts so stale flag reads are dropped.
  always_ff @(posedge CLK) begin
    if (RST || start_load) begin
      tag_vld_q <= '0;
    end else begin
      for (int i = int'(ReadLatency) - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
      end
      tag_vld_q[0] <= issue_q;
    end
  end

  // Tag addresses only matter when their valid bit is set.
  always_ff @(posedge CLK) begin
    for (int i = int'(ReadLatency) - 1; i > 0; i--) begin
      tag_addr_q[i] <= tag_addr_q[i-1];
    end
    tag_addr_q[0] <= addr_q;
  end

  // Flag history and shadow capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_prev_q <= 1'b0;
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      if (flag_sample) begin
        flag_prev_q <= bus.CTL_DOUT[CTL_FLAG_MOD_SET];
      end
      if (data_hit) begin
        shadow_q[ret_idx] <= bus.CTL_DOUT;
      end
    end
  end

  // Setting outputs move only on commit, all together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      update_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      req_rd_q      <= 1'b0;
      cycle0_q      <= '0;
      cycle1_q      <= '0;
      freq_div0_q   <= '0;
      freq_div1_q   <= '0;
      rep0_q        <= '0;
      rep1_q        <= '0;
      trans_mode_q  <= '0;
      trans_value_q <= '0;
    end else begin
      update_q <= commit;
      if (commit) begin
        mem_wr_q      <= shadow_q[0][0];
        req_rd_q      <= shadow_q[1][0];
        cycle0_q      <= shadow_q[2];
        freq_div0_q   <= {shadow_q[4], shadow_q[3]};
        cycle1_q      <= shadow_q[5];
        freq_div1_q   <= {shadow_q[7], shadow_q[6]};
        rep0_q        <= {shadow_q[9], shadow_q[8]};
        rep1_q        <= {shadow_q[11], shadow_q[10]};
        trans_mode_q  <= shadow_q[12][7:0];
        trans_value_q <= {shadow_q[16], shadow_q[15], shadow_q[14], shadow_q[13]};
      end
    end
  end

  // Upper bits of the flag-style words carry no setting.
  logic unused_bits;
  assign unused_bits = ^{shadow_q[0][15:1], shadow_q[1][15:1], shadow_q[12][15:8]};

  assign bus.CTL_ADDR         = addr_q;
  assign bus.UPDATE           = update_q;
  assign bus.MEM_WR_SEGMENT   = mem_wr_q;
  assign bus.REQ_RD_SEGMENT   = req_rd_q;
  assign bus.CYCLE0           = cycle0_q;
  assign bus.CYCLE1           = cycle1_q;
  assign bus.FREQ_DIV0        = freq_div0_q;
  assign bus.FREQ_DIV1        = freq_div1_q;
  assign bus.REP0             = rep0_q;
  assign bus.REP1             = rep1_q;
  assign bus.TRANSITION_MODE  = trans_mode_q;
  assign bus.TRANSITION_VALUE = trans_value_q;
endmodule
